// File: rtl/xnor_conv_pe_array_param.sv
// KxK binary-convolution PE array: XNOR against stored kernel, popcount, saturating slice accumulation.
// Optional threshold binarisation of the result is enabled by defining XNOR_ARRAY_THRESH_EN.
module xnor_conv_pe_array_param #(
    parameter int K          = 3,
    parameter int CH         = 1,
    parameter int PSUM_WIDTH = 4,
    parameter int ACC_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start,
    input  logic                   w_valid,
    input  logic                   w_bit,
    output logic                   weights_loaded,
    input  logic                   act_valid,
    output logic                   act_ready,
    input  logic [K*K*CH-1:0]      act_data,
    input  logic                   act_last,
    input  logic [ACC_WIDTH-1:0]   thr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_psum,
    output logic                   out_bit
);
    localparam int N  = K * K * CH;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t               state, state_nxt;
    logic [N-1:0]         weights;
    logic [N-1:0]         s1_bits;
    logic                 s1_valid;
    logic                 s1_last;
    logic [CW-1:0]        w_cnt;
    logic [ACC_WIDTH-1:0] acc;
    logic                 stall;
    logic                 accept;
    logic                 fire;
    logic                 load_done;
    logic [PSUM_WIDTH-1:0] pop;
    logic [ACC_WIDTH:0]   sum_wide;
    logic [ACC_WIDTH-1:0] sum;

    function automatic logic [PSUM_WIDTH-1:0] popcount(input logic [N-1:0] v);
        logic [PSUM_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + PSUM_WIDTH'(v[i]);
        end
        return c;
    endfunction

    assign load_done      = (w_cnt == CW'(N));
    assign weights_loaded = (state == RUN);
    assign stall          = out_valid && !out_ready;
    assign act_ready      = (state == RUN) && en && !stall;
    assign accept         = act_valid && act_ready;
    assign fire           = en && s1_valid && !stall && (state == RUN);

    assign pop      = popcount(s1_bits);
    assign sum_wide = {1'b0, acc} + (ACC_WIDTH + 1)'(pop);
    assign sum      = sum_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (en) begin
            if (start) begin
                state_nxt = LOAD;
            end else if (state == LOAD && load_done) begin
                state_nxt = RUN;
            end
        end
    end

    // The transition cycle (count already N) deliberately refuses further weight bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weights <= '0;
            w_cnt   <= '0;
        end else if (en) begin
            if (start) begin
                w_cnt <= '0;
            end else if (state == LOAD && w_valid && !load_done) begin
                weights <= (weights << 1) | N'(w_bit);
                w_cnt   <= w_cnt + CW'(1);
            end
        end
    end

`ifdef XNOR_ARRAY_THRESH_EN
    logic [ACC_WIDTH-1:0] thr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_q <= '0;
        end else if (en && start) begin
            thr_q <= thr;
        end
    end
`else
    logic unused_thr;
    assign unused_thr = ^thr;
    assign out_bit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_bits   <= '0;
            s1_last   <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_psum  <= '0;
`ifdef XNOR_ARRAY_THRESH_EN
            out_bit   <= 1'b0;
`endif
        end else if (en) begin
            if (start) begin
                s1_valid  <= 1'b0;
                acc       <= '0;
                out_valid <= 1'b0;
            end else begin
                if (accept) begin
                    s1_valid <= 1'b1;
                    s1_bits  <= ~(act_data ^ weights);
                    s1_last  <= act_last;
                end else if (fire) begin
                    s1_valid <= 1'b0;
                end

                if (out_ready) begin
                    out_valid <= 1'b0;
                end

                // A new result loading in the same cycle overrides the clear above.
                if (fire) begin
                    if (s1_last) begin
                        out_psum  <= sum;
                        out_valid <= 1'b1;
                        acc       <= '0;
`ifdef XNOR_ARRAY_THRESH_EN
                        out_bit   <= (sum >= thr_q);
`endif
                    end else begin
                        acc <= sum;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_xnor_conv_pe_array_param.sv
// Scoreboard bench for xnor_conv_pe_array_param (K=3, CH=1, ACC_WIDTH=8).
// Expected results come from a reference model fed by the observed input handshakes.
module tb_xnor_conv_pe_array_param;
    localparam int K       = 3;
    localparam int CH      = 1;
    localparam int N       = K * K * CH;
    localparam int ACC_W   = 8;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             start = 1'b0;
    logic             w_valid = 1'b0;
    logic             w_bit = 1'b0;
    logic             weights_loaded;
    logic             act_valid = 1'b0;
    logic             act_ready;
    logic [N-1:0]     act_data = '0;
    logic             act_last = 1'b0;
    logic [ACC_W-1:0] thr = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_psum;
    logic             out_bit;

    xnor_conv_pe_array_param #(.K(K), .CH(CH), .PSUM_WIDTH(4), .ACC_WIDTH(ACC_W)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .w_valid(w_valid), .w_bit(w_bit),
        .weights_loaded(weights_loaded), .act_valid(act_valid), .act_ready(act_ready),
        .act_data(act_data), .act_last(act_last), .thr(thr), .out_valid(out_valid),
        .out_ready(out_ready), .out_psum(out_psum), .out_bit(out_bit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int psum;
        int b;
    } exp_t;

    exp_t         sb[$];
    exp_t         e;
    int           n_vec = 0;
    int           n_err = 0;
    int           m_acc = 0;
    int           m_thr = 0;
    int           pc;
    int           s;
    logic [N-1:0] w_model = '0;
    logic [N-1:0] w;
    logic [ACC_W-1:0] held;
    bit           drv_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: sampled mid-cycle, so it sees exactly what the next edge will see.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_acc = 0;
        end else if (en) begin
            if (start) begin
                sb.delete();
                m_acc = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_extra_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_psum", out_psum, e.psum);
                        chk("sb_bit", out_bit, e.b);
                    end
                end
                if (act_valid && act_ready) begin
                    pc = $countones(~(act_data ^ w_model));
                    s = m_acc + pc;
                    if (s > ACC_MAX) s = ACC_MAX;
                    if (act_last) begin
                        e.psum = s;
`ifdef XNOR_ARRAY_THRESH_EN
                        e.b = (s >= m_thr) ? 1 : 0;
`else
                        e.b = 0;
`endif
                        sb.push_back(e);
                        m_acc = 0;
                    end else begin
                        m_acc = s;
                    end
                end
            end
        end
    end

    task automatic load_w(input logic [N-1:0] wv, input int t);
        start = 1'b1;
        thr = ACC_W'(t);
        tick();
        start = 1'b0;
        chk("start_clears_out_valid", out_valid, 0);
        for (int i = N - 1; i >= 0; i--) begin
            w_valid = 1'b1;
            w_bit = wv[i];
            tick();
        end
        w_valid = 1'b0;
        chk("ready_in_load", act_ready, 0);
        chk("loaded_early", weights_loaded, 0);
        tick();
        chk("weights_loaded", weights_loaded, 1);
        w_model = wv;
        m_thr = t;
    endtask

    task automatic send_beat(input logic [N-1:0] d, input logic last);
        int n;
        act_valid = 1'b1;
        act_data = d;
        act_last = last;
        n = 0;
        while (!act_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("accept_timeout", 1, 0);
        tick();
        act_valid = 1'b0;
        act_last = 1'b0;
    endtask

    task automatic wait_out_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk(tag, 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        w = 9'b101010101;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_psum", out_psum, 0);
        chk("rst_out_bit", out_bit, 0);
        chk("rst_act_ready", act_ready, 0);
        chk("rst_weights_loaded", weights_loaded, 0);
        tick();
        rst = 1'b0;
        en = 1'b1;
        tick();
        chk("idle_ready", act_ready, 0);

        // full match then latency
        load_w(w, 5);
        send_beat(w, 1'b1);
        chk("lat_early", out_valid, 0);
        tick();
        chk("lat_out_valid", out_valid, 1);
        chk("full_match_psum", out_psum, 9);
        drain();

        // zero match
        send_beat(~w, 1'b1);
        drain();

        // accumulation 4+5+9 then fresh group
        send_beat(w ^ 9'b000011111, 1'b0);
        send_beat(w ^ 9'b000001111, 1'b0);
        send_beat(w, 1'b1);
        send_beat(w, 1'b1);
        drain();

        // backpressure
        out_ready = 1'b0;
        fork
            begin
                send_beat(w, 1'b1);
                send_beat(~w, 1'b1);
                send_beat(w ^ 9'b000011111, 1'b1);
                send_beat(w ^ 9'b000001111, 1'b1);
            end
            begin
                wait_out_valid("bp_out_valid_timeout");
                chk("bp_act_ready_low", act_ready, 0);
                held = out_psum;
                for (int i = 0; i < 3; i++) begin
                    tick();
                    chk("bp_psum_hold", out_psum, held);
                    chk("bp_valid_hold", out_valid, 1);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // en low freezes the input side
        en = 1'b0;
        act_valid = 1'b1;
        act_data = w;
        act_last = 1'b1;
        #1;
        chk("en_low_ready", act_ready, 0);
        tick();
        tick();
        chk("en_low_no_out", out_valid, 0);
        act_valid = 1'b0;
        act_last = 1'b0;
        en = 1'b1;

        // random traffic with random backpressure
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    send_beat(N'($urandom), (i == 23) ? 1'b1 : 1'($urandom_range(0, 2) == 0));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // saturation: 29 full matches = 261 -> 255
        for (int i = 0; i < 29; i++) send_beat(w, (i == 28) ? 1'b1 : 1'b0);
        tick();
        chk("sat_psum", out_psum, ACC_MAX);
        drain();

        // restart during RUN drops the pending result
        out_ready = 1'b0;
        send_beat(w, 1'b1);
        wait_out_valid("restart_out_valid_timeout");
        load_w(9'b111000111, 3);
        out_ready = 1'b1;
        send_beat(9'b111000111, 1'b1);
        send_beat(9'b000111000, 1'b1);
        drain();

        // async reset mid-RUN with a result waiting
        out_ready = 1'b0;
        send_beat(9'b111000111, 1'b1);
        wait_out_valid("rstmid_out_valid_timeout");
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_act_ready", act_ready, 0);
        chk("rstmid_weights_loaded", weights_loaded, 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("rstmid_idle", weights_loaded, 0);
        chk("rstmid_psum_cleared", out_psum, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
